// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment scan driver.
// Scans DIGITS common-anode-style digit selects, decodes one nibble per slot,
// and double-buffers loaded values so the display only changes at frame wrap.
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]        pre;
  logic [IW-1:0]        idx;
  logic                 tick;
  logic                 wrap;
  logic [4*DIGITS-1:0]  disp_val;
  logic [DIGITS-1:0]    disp_dp;
  logic [4*DIGITS-1:0]  pend_val;
  logic [DIGITS-1:0]    pend_dp;
  logic                 pending;
  logic [DIGITS-1:0]    lz;
  logic                 zero_run;
  logic [3:0]           nib;
  logic                 blank;

  assign tick = (pre == PW'(DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Prescaler and digit index: idx steps once per slot and wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Registered pulse in the cycle after the wrapping tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= wrap;
  end

  // Double buffer: loads park in the pending buffer; the display only updates at wrap,
  // where a same-cycle load bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pending) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pending <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pending  <= 1'b1;
    end
  end

  // lz[k] is set when displayed nibbles k..DIGITS-1 are all zero.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_val[k*4 +: 4] == 4'd0);
      lz[k]    = zero_run;
    end
  end

  assign nib   = disp_val[idx*4 +: 4];
  assign blank = blank_lz && (idx != '0) && lz[idx];

  // Hex-to-segment decode for the selected digit, with leading-zero blanking.
  always_comb begin
    seg = 7'h00;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'h7E;
        4'h1: seg = 7'h30;
        4'h2: seg = 7'h6D;
        4'h3: seg = 7'h79;
        4'h4: seg = 7'h33;
        4'h5: seg = 7'h5B;
        4'h6: seg = 7'h5F;
        4'h7: seg = 7'h70;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h7B;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h1F;
        4'hC: seg = 7'h4E;
        4'hD: seg = 7'h3D;
        4'hE: seg = 7'h4F;
        default: seg = 7'h47;
      endcase
    end
  end

  assign dp = disp_dp[idx];
  assign an = DIGITS'(1) << idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4).
// The reference model tracks only the edge count since reset plus the
// displayed/pending values; scan position is derived arithmetically.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [6:0] HEX_TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        run;

  int vectors;
  int miscompares;

  int          cnt;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_pbuf;
  logic [3:0]  m_pbdp;
  logic        m_pend;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Gated clock so reset can be exercised with the clock stopped.
  always #5 if (run) clk = ~clk;

  function automatic int cur_digit();
    return (cnt / DIV) % DIGITS;
  endfunction

  function automatic logic [3:0] exp_an();
    return 4'(1 << cur_digit());
  endfunction

  function automatic logic exp_fd();
    return (cnt > 0) && (cnt % FRAME == 0);
  endfunction

  function automatic logic exp_dp();
    return m_dp[cur_digit()];
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    bit allz;
    d = cur_digit();
    allz = 1'b1;
    for (int k = d; k < DIGITS; k++)
      if (m_disp[k*4 +: 4] != 4'd0) allz = 1'b0;
    if (blank_lz && d > 0 && allz) return 7'h00;
    return HEX_TBL[m_disp[d*4 +: 4]];
  endfunction

  task automatic model_reset();
    cnt    = 0;
    m_disp = '0;
    m_dp   = '0;
    m_pbuf = '0;
    m_pbdp = '0;
    m_pend = 1'b0;
  endtask

  // One clock edge with the given load inputs; model updated to the post-edge state.
  task automatic advance(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load  = ld;
    value = v;
    dp_in = d;
    @(posedge clk);
    cnt++;
    if (cnt % FRAME == 0) begin
      if (ld) begin
        m_disp = v;
        m_dp   = d;
      end else if (m_pend) begin
        m_disp = m_pbuf;
        m_dp   = m_pbdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pbuf = v;
      m_pbdp = d;
      m_pend = 1'b1;
    end
    #1;
    load = 1'b0;
  endtask

  task automatic run_to_wrap(input logic ld, input logic [15:0] v, input logic [3:0] d);
    while (cnt % FRAME != FRAME - 1) advance(1'b0, 16'h0, 4'h0);
    advance(ld, v, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (an !== 4'b0001) begin miscompares++; $display("[TB] FAIL reset_an got=%b exp=0001", an); end
    vectors++;
    if (seg !== 7'h7E) begin miscompares++; $display("[TB] FAIL reset_seg got=%h exp=7e", seg); end
    vectors++;
    if (dp !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dp got=%b exp=0", dp); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fd got=%b exp=0", frame_done); end
    #2;
    rst_n = 1'b1;
    model_reset();
    run = 1'b1;
  endtask

  task automatic test_scan();
    int fd_count;
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance(1'b0, 16'h0, 4'h0);
      if (frame_done === 1'b1) fd_count++;
      vectors++;
      if (an !== exp_an()) begin miscompares++; $display("[TB] FAIL scan_an cnt=%0d got=%b exp=%b", cnt, an, exp_an()); end
      vectors++;
      if (frame_done !== exp_fd()) begin miscompares++; $display("[TB] FAIL scan_fd cnt=%0d got=%b exp=%b", cnt, frame_done, exp_fd()); end
    end
    vectors++;
    if (fd_count != 2) begin miscompares++; $display("[TB] FAIL scan_fd_count got=%0d exp=2", fd_count); end
  endtask

  task automatic test_double_buffer();
    logic [6:0] want [4];
    int d;
    want = '{7'h47, 7'h79, 7'h77, 7'h30};
    while (cnt % FRAME != 4) advance(1'b0, 16'h0, 4'h0);
    advance(1'b1, 16'h1A3F, 4'b0100);
    vectors++;
    if (seg !== 7'h7E) begin miscompares++; $display("[TB] FAIL db_hold cnt=%0d got=%h exp=7e", cnt, seg); end
    while (cnt % FRAME != FRAME - 1) begin
      advance(1'b0, 16'h0, 4'h0);
      vectors++;
      if (seg !== 7'h7E || dp !== 1'b0) begin
        miscompares++; $display("[TB] FAIL db_tear cnt=%0d seg=%h dp=%b exp seg=7e dp=0", cnt, seg, dp);
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      advance(1'b0, 16'h0, 4'h0);
      d = cur_digit();
      vectors++;
      if (seg !== want[d] || seg !== exp_seg()) begin
        miscompares++; $display("[TB] FAIL db_seg digit=%0d got=%h exp=%h", d, seg, want[d]);
      end
      vectors++;
      if (dp !== (d == 2)) begin miscompares++; $display("[TB] FAIL db_dp digit=%0d got=%b exp=%b", d, dp, (d == 2)); end
    end
  endtask

  task automatic test_last_wins();
    run_to_wrap(1'b0, 16'h0, 4'h0);
    advance(1'b0, 16'h0, 4'h0);
    advance(1'b1, 16'h1111, 4'h0);
    advance(1'b0, 16'h0, 4'h0);
    advance(1'b1, 16'h2222, 4'h0);
    run_to_wrap(1'b0, 16'h0, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) advance(1'b0, 16'h0, 4'h0);
      vectors++;
      if (seg !== 7'h6D || seg !== exp_seg()) begin
        miscompares++; $display("[TB] FAIL lastwins_seg cnt=%0d got=%h exp=6d", cnt, seg);
      end
    end
    advance(1'b1, 16'h3333, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) advance(1'b0, 16'h0, 4'h0);
      vectors++;
      if (seg !== 7'h79 || seg !== exp_seg()) begin
        miscompares++; $display("[TB] FAIL wrapload_seg cnt=%0d got=%h exp=79", cnt, seg);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] want_a [4];
    logic [6:0] want_b [4];
    int d;
    want_a = '{7'h7E, 7'h70, 7'h00, 7'h00};
    want_b = '{7'h7E, 7'h00, 7'h00, 7'h00};
    blank_lz = 1'b1;
    run_to_wrap(1'b1, 16'h0070, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) advance(1'b0, 16'h0, 4'h0);
      d = cur_digit();
      vectors++;
      if (seg !== want_a[d] || seg !== exp_seg()) begin
        miscompares++; $display("[TB] FAIL blank0070 digit=%0d got=%h exp=%h", d, seg, want_a[d]);
      end
      vectors++;
      if (an !== exp_an()) begin miscompares++; $display("[TB] FAIL blank_an cnt=%0d got=%b exp=%b", cnt, an, exp_an()); end
    end
    run_to_wrap(1'b1, 16'h0000, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) advance(1'b0, 16'h0, 4'h0);
      d = cur_digit();
      vectors++;
      if (seg !== want_b[d] || seg !== exp_seg()) begin
        miscompares++; $display("[TB] FAIL blank0000 digit=%0d got=%h exp=%h", d, seg, want_b[d]);
      end
    end
    blank_lz = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      advance(1'b0, 16'h0, 4'h0);
      vectors++;
      if (seg !== 7'h7E) begin miscompares++; $display("[TB] FAIL noblank cnt=%0d got=%h exp=7e", cnt, seg); end
    end
  endtask

  task automatic test_reset_mid();
    run_to_wrap(1'b1, 16'h5A5A, 4'b1010);
    advance(1'b0, 16'h0, 4'h0);
    advance(1'b1, 16'h1234, 4'hF);
    while (cnt % FRAME != 10) advance(1'b0, 16'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (an !== 4'b0001) begin miscompares++; $display("[TB] FAIL midrst_an got=%b exp=0001", an); end
    vectors++;
    if (seg !== 7'h7E) begin miscompares++; $display("[TB] FAIL midrst_seg got=%h exp=7e", seg); end
    vectors++;
    if (dp !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_dp got=%b exp=0", dp); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_fd got=%b exp=0", frame_done); end
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance(1'b0, 16'h0, 4'h0);
      vectors++;
      if (seg !== 7'h7E || dp !== 1'b0) begin
        miscompares++; $display("[TB] FAIL postrst_seg cnt=%0d seg=%h dp=%b exp seg=7e dp=0", cnt, seg, dp);
      end
      vectors++;
      if (an !== exp_an()) begin miscompares++; $display("[TB] FAIL postrst_an cnt=%0d got=%b exp=%b", cnt, an, exp_an()); end
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] v;
    logic [3:0]  d;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 5) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      d  = 4'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      advance(ld, v, d);
      vectors++;
      if (an !== exp_an()) begin miscompares++; $display("[TB] FAIL rnd_an cnt=%0d got=%b exp=%b", cnt, an, exp_an()); end
      vectors++;
      if (seg !== exp_seg()) begin miscompares++; $display("[TB] FAIL rnd_seg cnt=%0d got=%h exp=%h", cnt, seg, exp_seg()); end
      vectors++;
      if (dp !== exp_dp()) begin miscompares++; $display("[TB] FAIL rnd_dp cnt=%0d got=%b exp=%b", cnt, dp, exp_dp()); end
      vectors++;
      if (frame_done !== exp_fd()) begin miscompares++; $display("[TB] FAIL rnd_fd cnt=%0d got=%b exp=%b", cnt, frame_done, exp_fd()); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    run         = 1'b0;
    rst_n       = 1'b1;
    load        = 1'b0;
    value       = '0;
    dp_in       = '0;
    blank_lz    = 1'b0;
    model_reset();
    #3;
    test_reset();
    test_scan();
    test_double_buffer();
    test_last_wins();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
